// File: rtl/demux_2line_ctrl.sv
// Routes one byte at a time from a valid/ready source to one of two demux lines, with an optional sink timeout.
// Build with DEMUX_2LINE_CTRL_CNT_EN defined to get per-line delivered-byte counters on cnt0/cnt1.
module demux_2line_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] in_data,
  input  logic       in_dest,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       sel,
  output logic [7:0] data_q,
  output logic       out0_valid,
  output logic       out1_valid,
  input  logic       out0_ready,
  input  logic       out1_ready,
  output logic       drop,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The timeout fires in the HOLD cycle whose wait count is one short of TIMEOUT
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [WAIT_W-1:0]   wait_r;
  logic                in_ready_r;
  logic                sel_r;
  logic [7:0]          data_r;
  logic                out0_valid_r;
  logic                out1_valid_r;
  logic                drop_r;
  logic                accept_s;
  logic                timeout_s;
  logic                hold_wait_s;
  logic                wait_hit_s;

  assign wait_hit_s = (TIMEOUT > 0) && (wait_r == WAIT_LAST);

  // Next-state decode; delivery is checked before timeout so a late ready still wins
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    timeout_s   = 1'b0;
    hold_wait_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_ready_r && in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = in_dest ? HOLD1 : HOLD0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD0: begin
        if (out0_ready) begin
          state_nxt_s = IDLE;
        end else if (wait_hit_s) begin
          hold_wait_s = 1'b1;
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          hold_wait_s = 1'b1;
          state_nxt_s = HOLD0;
        end
      end
      HOLD1: begin
        if (out1_ready) begin
          state_nxt_s = IDLE;
        end else if (wait_hit_s) begin
          hold_wait_s = 1'b1;
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          hold_wait_s = 1'b1;
          state_nxt_s = HOLD1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Controller state with outputs registered from the next state
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r      <= IDLE;
      in_ready_r   <= 1'b0;
      out0_valid_r <= 1'b0;
      out1_valid_r <= 1'b0;
      drop_r       <= 1'b0;
      data_r       <= 8'd0;
      sel_r        <= 1'b0;
      wait_r       <= '0;
    end else begin
      state_r      <= state_nxt_s;
      in_ready_r   <= (state_nxt_s == IDLE);
      out0_valid_r <= (state_nxt_s == HOLD0);
      out1_valid_r <= (state_nxt_s == HOLD1);
      drop_r       <= timeout_s;
      if (accept_s) begin
        data_r <= in_data;
        sel_r  <= in_dest;
        wait_r <= '0;
      end else if (hold_wait_s) begin
        wait_r <= wait_r + 1'b1;
      end else begin
        wait_r <= wait_r;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign sel        = sel_r;
  assign data_q     = data_r;
  assign out0_valid = out0_valid_r;
  assign out1_valid = out1_valid_r;
  assign drop       = drop_r;

`ifdef DEMUX_2LINE_CTRL_CNT_EN
  logic       deliver0_s;
  logic       deliver1_s;
  logic [7:0] cnt0_r;
  logic [7:0] cnt1_r;

  assign deliver0_s = (state_r == HOLD0) && out0_ready;
  assign deliver1_s = (state_r == HOLD1) && out1_ready;

  // Per-line delivered-byte counters, free-running wrap at 255
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt0_r <= 8'd0;
      cnt1_r <= 8'd0;
    end else begin
      if (deliver0_s) begin
        cnt0_r <= cnt0_r + 8'd1;
      end else begin
        cnt0_r <= cnt0_r;
      end
      if (deliver1_s) begin
        cnt1_r <= cnt1_r + 8'd1;
      end else begin
        cnt1_r <= cnt1_r;
      end
    end
  end

  assign cnt0 = cnt0_r;
  assign cnt1 = cnt1_r;
`else
  assign cnt0 = 8'd0;
  assign cnt1 = 8'd0;
`endif

endmodule
